// File: rtl/univ_cnt_pkg.sv
// Shared encodings for the universal modulo counter: bound-mode and direction
// constants, plus the per-cycle operation select used by the top-level mux.
package univ_cnt_pkg;

  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_HOLD = 1'b1;
  localparam logic DIR_DN   = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } cnt_op_e;

  // Clear beats load beats count; anything else holds.
  function automatic cnt_op_e sel_op(input logic clr, input logic ld, input logic cnt);
    if (clr)      return OP_CLR;
    else if (ld)  return OP_LOAD;
    else if (cnt) return OP_COUNT;
    else          return OP_HOLD;
  endfunction

endpackage

// File: rtl/univ_cnt_next.sv
// Combinational next-count and bound-event generator. Pure function of the
// current count, step, bounds, direction and bound mode.
module univ_cnt_next
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic         up,
  input  logic         sat,
  output logic [N-1:0] q_next,
  output logic         evt
);

  // One extra bit so q + step and lo + step never truncate before comparing.
  logic [N:0] sum_up;
  logic [N:0] lo_plus_step;

  assign sum_up       = {1'b0, q}  + {1'b0, step};
  assign lo_plus_step = {1'b0, lo} + {1'b0, step};

  // NOTE: every output gets a default first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next = q;
    evt    = 1'b0;
    if (step != '0) begin
      case (up)
        DIR_UP: begin
          if (sum_up > {1'b0, hi}) begin
            evt    = 1'b1;
            q_next = (sat == SAT_HOLD) ? hi : lo;
          end else begin
            q_next = sum_up[N-1:0];
          end
        end
        DIR_DN: begin
          if ({1'b0, q} < lo_plus_step) begin
            evt    = 1'b1;
            q_next = (sat == SAT_WRAP) ? hi : lo;
          end else begin
            q_next = q - step;
          end
        end
        default: begin
          q_next = q;
          evt    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/univ_mod_counter.sv
// Programmable-step up/down counter between run-time bounds, with wrap or
// saturate behaviour, registered terminal-count pulse and sticky overflow.
module univ_mod_counter
  import univ_cnt_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] d,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  output logic [N-1:0] q,
  output logic         max,
  output logic         min,
  output logic         tc,
  output logic         ovf
);

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic [N-1:0] cnt_next;
  logic         cnt_evt;
  cnt_op_e      op;

  univ_cnt_next #(.N(N)) u_next (
    .q      (q_q),
    .step   (step),
    .lo     (lo),
    .hi     (hi),
    .up     (up),
    .sat    (sat),
    .q_next (cnt_next),
    .evt    (cnt_evt)
  );

  assign op = sel_op(syn_clr, load, en);

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unique case (op)
      OP_CLR: begin
        q_d   = lo;
        ovf_d = 1'b0;
      end
      OP_LOAD:  q_d = d;
      OP_COUNT: begin
        q_d   = cnt_next;
        tc_d  = cnt_evt;
        ovf_d = ovf_q | cnt_evt;
      end
      default: q_d = q_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign max = (q_q == hi);
  assign min = (q_q == lo);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Self-checking bench for univ_mod_counter: directed bound/priority/reset
// scenarios followed by randomized traffic against an integer reference model.
module tb_univ_mod_counter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         syn_clr, load, en, up, sat;
  logic [N-1:0] d, step, lo, hi;
  logic [N-1:0] q_w;
  logic         max_w, min_w, tc_w, ovf_w;

  int errors = 0;
  int checks = 0;

  // Reference state kept as plain integers.
  int m_q;
  int m_tc;
  int m_ovf;

  always #5 clk = ~clk;

  univ_mod_counter #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .syn_clr (syn_clr),
    .load    (load),
    .en      (en),
    .up      (up),
    .sat     (sat),
    .d       (d),
    .step    (step),
    .lo      (lo),
    .hi      (hi),
    .q       (q_w),
    .max     (max_w),
    .min     (min_w),
    .tc      (tc_w),
    .ovf     (ovf_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},   32'(q_w),   32'(m_q));
    check({tag, ".tc"},  32'(tc_w),  32'(m_tc));
    check({tag, ".ovf"}, 32'(ovf_w), 32'(m_ovf));
    check({tag, ".max"}, 32'(max_w), 32'(m_q == int'(hi)));
    check({tag, ".min"}, 32'(min_w), 32'(m_q == int'(lo)));
  endtask

  // Behavioural update from the operation rules, using unbounded integers.
  task automatic model_edge();
    int lo_i, hi_i, st_i;
    bit evt;
    lo_i = int'(lo);
    hi_i = int'(hi);
    st_i = int'(step);
    evt  = 1'b0;
    if (!reset_n) begin
      m_q = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    if (syn_clr) begin
      m_q = lo_i; m_tc = 0; m_ovf = 0;
    end else if (load) begin
      m_q = int'(d); m_tc = 0;
    end else if (en) begin
      if (st_i != 0) begin
        if (up) begin
          if (m_q + st_i > hi_i) begin
            evt = 1'b1;
            m_q = sat ? hi_i : lo_i;
          end else m_q = m_q + st_i;
        end else begin
          if (m_q < lo_i + st_i) begin
            evt = 1'b1;
            m_q = sat ? lo_i : hi_i;
          end else m_q = m_q - st_i;
        end
      end
      m_tc = evt ? 1 : 0;
      if (evt) m_ovf = 1;
    end else begin
      m_tc = 0;
    end
  endtask

  // Inputs are set at the falling edge; model and DUT advance on the rising
  // edge; outputs are compared at the next falling edge.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_ctrl(input logic c, input logic l, input logic e,
                          input logic u, input logic s);
    syn_clr = c; load = l; en = e; up = u; sat = s;
  endtask

  initial begin
    reset_n = 1'b0;
    set_ctrl(0, 0, 0, 1, 0);
    d = '0; step = 8'd3; lo = 8'd10; hi = 8'd20;
    m_q = 0; m_tc = 0; m_ovf = 0;

    // Reset state
    #12;
    @(negedge clk);
    check_all("reset");

    // Up, wrap, step 3 from out-of-range 0 into [10,20]
    reset_n = 1'b1;
    set_ctrl(0, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) cycle("up_wrap");
    check("wrap_q_lo", 32'(q_w), 32'd10);
    check("wrap_tc", 32'(tc_w), 32'd1);
    check("wrap_ovf", 32'(ovf_w), 32'd1);
    cycle("after_wrap");
    check("after_wrap_tc", 32'(tc_w), 32'd0);

    // Saturate at hi, re-pulse, then idle
    d = 8'd18; set_ctrl(0, 1, 0, 1, 1);
    cycle("load18");
    step = 8'd4; set_ctrl(0, 0, 1, 1, 1);
    cycle("sat_hi1");
    check("sat_hi1_q", 32'(q_w), 32'd20);
    cycle("sat_hi2");
    check("sat_hi2_tc", 32'(tc_w), 32'd1);
    set_ctrl(0, 0, 0, 1, 1);
    cycle("sat_idle");
    check("sat_idle_ovf", 32'(ovf_w), 32'd1);

    // Down wrap and down saturate
    lo = 8'd5; hi = 8'd250; step = 8'd7; d = 8'd10;
    set_ctrl(0, 1, 0, 0, 0);
    cycle("load10");
    set_ctrl(0, 0, 1, 0, 0);
    cycle("dn_wrap");
    check("dn_wrap_max", 32'(max_w), 32'd1);
    set_ctrl(0, 1, 0, 0, 1);
    cycle("load10b");
    set_ctrl(0, 0, 1, 0, 1);
    cycle("dn_sat");
    check("dn_sat_min", 32'(min_w), 32'd1);

    // Priority: clear over load over enable, then load over enable
    d = 8'h55; lo = 8'd2;
    set_ctrl(1, 1, 1, 1, 0);
    cycle("prio_clr");
    check("prio_clr_q", 32'(q_w), 32'd2);
    set_ctrl(0, 1, 1, 1, 0);
    cycle("prio_load");
    check("prio_load_q", 32'(q_w), 32'h55);

    // Wide sum must not truncate: 100 + 200 > 255
    lo = 8'd3; hi = 8'd255; step = 8'd200; d = 8'd100;
    set_ctrl(0, 1, 0, 1, 0);
    cycle("load100");
    set_ctrl(0, 0, 1, 1, 0);
    cycle("no_trunc");
    check("no_trunc_q", 32'(q_w), 32'd3);

    // Asynchronous reset mid-cycle, held across edges
    lo = 8'd1; hi = 8'd40; step = 8'd5;
    set_ctrl(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle("pre_arst");
    #2 reset_n = 1'b0;
    m_q = 0; m_tc = 0; m_ovf = 0;
    #1 check_all("arst_now");
    for (int i = 0; i < 2; i++) cycle("arst_hold");
    reset_n = 1'b1;

    // Randomized traffic, bounds kept ordered (lo <= hi)
    for (int i = 0; i < 400; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (i % 16 == 0) begin
        lo = 8'(a < b ? a : b);
        hi = 8'(a < b ? b : a);
      end
      step = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      d    = 8'($urandom_range(0, 255));
      set_ctrl($urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
